// File: rtl/inst_rom_arbiter.sv
// Instruction ROM arbiter: CPU fetch has priority, debug port is protected by a
// starvation counter; one ROM access per cycle, registered response one cycle later.
module inst_rom_arbiter #(
   parameter int ADDR_W     = 5,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              cpu_req,
   input  logic [31:0]       cpu_addr,
   output logic              cpu_gnt,
   output logic              cpu_rvalid,
   output logic [31:0]       cpu_rdata,
   output logic              cpu_err,
   input  logic              dbg_req,
   input  logic [ADDR_W-1:0] dbg_addr,
   output logic              dbg_gnt,
   output logic              dbg_rvalid,
   output logic [31:0]       dbg_rdata,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [31:0]       rom_inst
);

   localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

   typedef enum logic [1:0] {
      OWN_IDLE = 2'd0,
      OWN_CPU  = 2'd1,
      OWN_DBG  = 2'd2
   } owner_t;

   owner_t      owner_reg, owner_next;
   logic [2:0]  starve_cnt_reg, starve_cnt_next;
   logic [31:0] cpu_rdata_reg, dbg_rdata_reg;
   logic        cpu_err_reg;
   logic        cpu_bad;
   logic        dbg_forced;

   assign cpu_bad    = (cpu_addr[1:0] != 2'b00) || (cpu_addr[31:ADDR_W+2] != '0);
   assign dbg_forced = dbg_req && (starve_cnt_reg == STARVE_LIM);

   always_comb begin
      cpu_gnt         = 1'b0;
      dbg_gnt         = 1'b0;
      rom_addr        = '0;
      owner_next      = OWN_IDLE;
      starve_cnt_next = 3'd0;

      if (cpu_req && !dbg_forced) begin
         cpu_gnt    = 1'b1;
         owner_next = OWN_CPU;
         // Bad addresses are still accepted, but never reach the ROM.
         if (!cpu_bad) begin
            rom_addr = cpu_addr[ADDR_W+1:2];
         end
      end else if (dbg_req) begin
         dbg_gnt    = 1'b1;
         owner_next = OWN_DBG;
         rom_addr   = dbg_addr;
      end

      if (dbg_req && !dbg_gnt) begin
         starve_cnt_next = (starve_cnt_reg == STARVE_LIM) ? starve_cnt_reg
                                                          : starve_cnt_reg + 3'd1;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         owner_reg      <= OWN_IDLE;
         starve_cnt_reg <= 3'd0;
         cpu_rdata_reg  <= 32'h0;
         cpu_err_reg    <= 1'b0;
         dbg_rdata_reg  <= 32'h0;
      end else begin
         owner_reg      <= owner_next;
         starve_cnt_reg <= starve_cnt_next;
         if (cpu_gnt) begin
            cpu_rdata_reg <= cpu_bad ? 32'h0 : rom_inst;
            cpu_err_reg   <= cpu_bad;
         end
         if (dbg_gnt) begin
            dbg_rdata_reg <= rom_inst;
         end
      end
   end

   // The last-cycle winner doubles as the response-valid flag.
   assign cpu_rvalid = (owner_reg == OWN_CPU);
   assign dbg_rvalid = (owner_reg == OWN_DBG);
   assign cpu_rdata  = cpu_rdata_reg;
   assign cpu_err    = cpu_err_reg;
   assign dbg_rdata  = dbg_rdata_reg;

endmodule

// File: tb/tb_inst_rom_arbiter.sv
// Directed bench for inst_rom_arbiter: per-cycle vector table plus hand-written
// reset sequences; the bench ROM returns 32'hA5000000 | word address.
module tb_inst_rom_arbiter;

   logic        clk = 1'b0;
   logic        resetn;
   logic        cpu_req;
   logic [31:0] cpu_addr;
   logic        cpu_gnt, cpu_rvalid, cpu_err;
   logic [31:0] cpu_rdata;
   logic        dbg_req;
   logic [4:0]  dbg_addr;
   logic        dbg_gnt, dbg_rvalid;
   logic [31:0] dbg_rdata;
   logic [4:0]  rom_addr;
   logic [31:0] rom_inst;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   assign rom_inst = 32'hA500_0000 | {27'd0, rom_addr};

   inst_rom_arbiter #(.ADDR_W(5), .STARVE_MAX(4)) dut (
      .clk(clk), .resetn(resetn),
      .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_gnt(cpu_gnt),
      .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
      .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_gnt(dbg_gnt),
      .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
      .rom_addr(rom_addr), .rom_inst(rom_inst)
   );

   typedef struct {
      logic        creq;
      logic [31:0] caddr;
      logic        dreq;
      logic [4:0]  daddr;
      logic        cgnt;
      logic        dgnt;
      logic [4:0]  raddr;
      logic        crv;
      logic [31:0] crd;
      logic        cerr;
      logic        drv;
      logic [31:0] drd;
   } vec_t;

   vec_t vecs[29];
   int   nvec = 0;

   task automatic add(input logic creq, input logic [31:0] caddr,
                      input logic dreq, input logic [4:0] daddr,
                      input logic cgnt, input logic dgnt, input logic [4:0] raddr,
                      input logic crv, input logic [31:0] crd, input logic cerr,
                      input logic drv, input logic [31:0] drd);
      vecs[nvec] = '{creq, caddr, dreq, daddr, cgnt, dgnt, raddr, crv, crd, cerr, drv, drd};
      nvec++;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   initial begin
      // creq caddr dreq daddr | cgnt dgnt raddr | crv crd cerr drv drd
      // single CPU fetch
      add(1, 32'h08, 0, 0,   1, 0, 2,    0, 32'h0,        0, 0, 32'h0);
      add(0, 32'h00, 0, 0,   0, 0, 0,    1, 32'hA5000002, 0, 0, 32'h0);
      // CPU streaming with debug starving: debug forced in cycle 4
      add(1, 32'h00, 1, 22,  1, 0, 0,    0, 32'hA5000002, 0, 0, 32'h0);
      add(1, 32'h04, 1, 22,  1, 0, 1,    1, 32'hA5000000, 0, 0, 32'h0);
      add(1, 32'h08, 1, 22,  1, 0, 2,    1, 32'hA5000001, 0, 0, 32'h0);
      add(1, 32'h0C, 1, 22,  1, 0, 3,    1, 32'hA5000002, 0, 0, 32'h0);
      add(1, 32'h10, 1, 22,  0, 1, 22,   1, 32'hA5000003, 0, 0, 32'h0);
      add(1, 32'h10, 0, 0,   1, 0, 4,    0, 32'hA5000003, 0, 1, 32'hA5000016);
      add(1, 32'h14, 0, 0,   1, 0, 5,    1, 32'hA5000004, 0, 0, 32'hA5000016);
      add(1, 32'h18, 0, 0,   1, 0, 6,    1, 32'hA5000005, 0, 0, 32'hA5000016);
      add(1, 32'h1C, 0, 0,   1, 0, 7,    1, 32'hA5000006, 0, 0, 32'hA5000016);
      // misaligned and out-of-range CPU addresses
      add(1, 32'h06, 0, 0,   1, 0, 0,    1, 32'hA5000007, 0, 0, 32'hA5000016);
      add(1, 32'h80, 0, 0,   1, 0, 0,    1, 32'h0,        1, 0, 32'hA5000016);
      add(0, 32'h00, 0, 0,   0, 0, 0,    1, 32'h0,        1, 0, 32'hA5000016);
      // debug-only back-to-back reads
      add(0, 32'h00, 1, 5,   0, 1, 5,    0, 32'h0,        1, 0, 32'hA5000016);
      add(0, 32'h00, 1, 3,   0, 1, 3,    0, 32'h0,        1, 1, 32'hA5000005);
      add(0, 32'h00, 1, 31,  0, 1, 31,   0, 32'h0,        1, 1, 32'hA5000003);
      add(0, 32'h00, 0, 0,   0, 0, 0,    0, 32'h0,        1, 1, 32'hA500001F);
      add(0, 32'h00, 0, 0,   0, 0, 0,    0, 32'h0,        1, 0, 32'hA500001F);
      // debug drops after 2 denials; counter restarts, forced after 4 more
      add(1, 32'h00, 1, 9,   1, 0, 0,    0, 32'h0,        1, 0, 32'hA500001F);
      add(1, 32'h04, 1, 9,   1, 0, 1,    1, 32'hA5000000, 0, 0, 32'hA500001F);
      add(1, 32'h08, 0, 0,   1, 0, 2,    1, 32'hA5000001, 0, 0, 32'hA500001F);
      add(1, 32'h0C, 1, 9,   1, 0, 3,    1, 32'hA5000002, 0, 0, 32'hA500001F);
      add(1, 32'h10, 1, 9,   1, 0, 4,    1, 32'hA5000003, 0, 0, 32'hA500001F);
      add(1, 32'h14, 1, 9,   1, 0, 5,    1, 32'hA5000004, 0, 0, 32'hA500001F);
      add(1, 32'h18, 1, 9,   1, 0, 6,    1, 32'hA5000005, 0, 0, 32'hA500001F);
      add(1, 32'h1C, 1, 9,   0, 1, 9,    1, 32'hA5000006, 0, 0, 32'hA500001F);
      // counter cleared by the forced grant: CPU wins the next contested cycle
      add(1, 32'h1C, 1, 9,   1, 0, 7,    0, 32'hA5000006, 0, 1, 32'hA5000009);
      add(0, 32'h00, 0, 0,   0, 0, 0,    1, 32'hA5000007, 0, 0, 32'hA5000009);

      // reset state
      resetn   = 1'b0;
      cpu_req  = 1'b0;
      cpu_addr = 32'h0;
      dbg_req  = 1'b0;
      dbg_addr = 5'd0;
      repeat (2) @(posedge clk);
      #1;
      check("reset cpu_rvalid", {31'd0, cpu_rvalid}, 32'd0);
      check("reset dbg_rvalid", {31'd0, dbg_rvalid}, 32'd0);
      check("reset cpu_err",    {31'd0, cpu_err},    32'd0);
      check("reset cpu_rdata",  cpu_rdata,           32'h0);
      check("reset dbg_rdata",  dbg_rdata,           32'h0);
      check("reset rom_addr",   {27'd0, rom_addr},   32'd0);
      // grant is combinational even in reset, but the transfer is discarded
      cpu_req  = 1'b1;
      cpu_addr = 32'h08;
      #1;
      check("reset cpu_gnt",    {31'd0, cpu_gnt},    32'd1);
      @(posedge clk);
      #1;
      check("reset discard cpu_rvalid", {31'd0, cpu_rvalid}, 32'd0);
      @(negedge clk);
      cpu_req = 1'b0;
      resetn  = 1'b1;
      @(posedge clk);
      #1;
      check("post-reset cpu_rvalid", {31'd0, cpu_rvalid}, 32'd0);
      $display("reset sequence done");

      for (int i = 0; i < nvec; i++) begin
         @(posedge clk);
         #1;
         cpu_req  = vecs[i].creq;
         cpu_addr = vecs[i].caddr;
         dbg_req  = vecs[i].dreq;
         dbg_addr = vecs[i].daddr;
         #2;
         check($sformatf("row%0d cpu_gnt", i),    {31'd0, cpu_gnt},    {31'd0, vecs[i].cgnt});
         check($sformatf("row%0d dbg_gnt", i),    {31'd0, dbg_gnt},    {31'd0, vecs[i].dgnt});
         check($sformatf("row%0d rom_addr", i),   {27'd0, rom_addr},   {27'd0, vecs[i].raddr});
         check($sformatf("row%0d cpu_rvalid", i), {31'd0, cpu_rvalid}, {31'd0, vecs[i].crv});
         check($sformatf("row%0d cpu_rdata", i),  cpu_rdata,           vecs[i].crd);
         check($sformatf("row%0d cpu_err", i),    {31'd0, cpu_err},    {31'd0, vecs[i].cerr});
         check($sformatf("row%0d dbg_rvalid", i), {31'd0, dbg_rvalid}, {31'd0, vecs[i].drv});
         check($sformatf("row%0d dbg_rdata", i),  dbg_rdata,           vecs[i].drd);
         $display("row %0d: creq=%b caddr=%h dreq=%b daddr=%0d -> cgnt=%b dgnt=%b rom_addr=%0d crv=%b crd=%h cerr=%b drv=%b drd=%h",
                  i, cpu_req, cpu_addr, dbg_req, dbg_addr, cpu_gnt, dbg_gnt, rom_addr,
                  cpu_rvalid, cpu_rdata, cpu_err, dbg_rvalid, dbg_rdata);
      end

      // reset asserted during the response cycle
      @(posedge clk);
      #1;
      cpu_req  = 1'b1;
      cpu_addr = 32'h10;
      dbg_req  = 1'b0;
      #2;
      check("midreset cpu_gnt", {31'd0, cpu_gnt}, 32'd1);
      @(posedge clk);
      #1;
      cpu_req = 1'b0;
      check("midreset pre cpu_rvalid", {31'd0, cpu_rvalid}, 32'd1);
      check("midreset pre cpu_rdata",  cpu_rdata,           32'hA5000004);
      resetn = 1'b0;
      #1;
      check("midreset cpu_rvalid", {31'd0, cpu_rvalid}, 32'd0);
      check("midreset cpu_rdata",  cpu_rdata,           32'h0);
      @(negedge clk);
      resetn = 1'b1;
      for (int k = 0; k < 2; k++) begin
         @(posedge clk);
         #1;
         check($sformatf("after release%0d cpu_rvalid", k), {31'd0, cpu_rvalid}, 32'd0);
         check($sformatf("after release%0d dbg_rvalid", k), {31'd0, dbg_rvalid}, 32'd0);
      end
      $display("mid-operation reset sequence done");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
